guess_game_ctrl: RTL and testbench

- Sequencer for the nibble-comparison datapath on the switch/LED/seven-segment board.
- Runs a two-player guessing game:
  - Player 1 latches a secret nibble from switches[3:0].
  - Player 2 submits guesses with a button.
  - Each guess is compared against the secret, and a high/low/equal result is displayed.
- Counts attempts and ends in WIN or LOSE.
- Owns the button synchroniser, edge detector, attempt counter, result hold timer and all display registers.

---
 rtl/guess_game_ctrl_if.sv | 25 ++
 rtl/guess_game_ctrl.sv | 165 ++++++++++++++++
 tb/tb_guess_game_ctrl.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/guess_game_ctrl_if.sv
// Board-side signals of the guessing game: button and switches in,
// LEDs and six seven-segment digits out.
interface guess_game_ctrl_if;
  logic       btn;
  logic [9:0] switches;
  logic [9:0] leds;
  logic [7:0] hex0;
  logic [7:0] hex1;
  logic [7:0] hex2;
  logic [7:0] hex3;
  logic [7:0] hex4;
  logic [7:0] hex5;

  // Board / stimulus side: drives the button and switches
  modport master (
    output btn, switches,
    input  leds, hex0, hex1, hex2, hex3, hex4, hex5
  );

  // Controller side
  modport slave (
    input  btn, switches,
    output leds, hex0, hex1, hex2, hex3, hex4, hex5
  );
endinterface

// File: rtl/guess_game_ctrl.sv
// Two-player nibble guessing game sequencer: button synchroniser and edge
// detector, secret latch, attempt counter, result hold timer and all
// LED / seven-segment display registers.
module guess_game_ctrl #(
  parameter int MAX_TRIES   = 7,
  parameter int HOLD_CYCLES = 25000000
) (
  input  logic               clk,
  input  logic               reset,
  guess_game_ctrl_if.slave   bus
);

  localparam int TW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  localparam logic [7:0] GLYPH_L     = 8'b1100_0111;
  localparam logic [7:0] GLYPH_H     = 8'b1000_1001;
  localparam logic [7:0] GLYPH_E     = 8'b1000_0110;
  localparam logic [7:0] GLYPH_BLANK = 8'hFF;

  typedef enum logic [2:0] {SETUP, GUESS, HOLD, WIN, LOSE} state_t;

  state_t        state_reg, state_next;
  logic [3:0]    secret_reg, secret_next;
  logic [3:0]    guess_reg, guess_next;
  logic [3:0]    attempts_reg, attempts_next;
  logic [TW-1:0] timer_reg, timer_next;
  logic [2:0]    res_reg, res_next;      // {equal, high, low}
  logic          s1_reg, s2_reg, s3_reg;
  logic          press;
  logic [3:0]    g;
  logic [3:0]    tries_inc;
  logic [9:0]    leds_reg, leds_next;
  logic [7:0]    hex0_reg, hex0_next;
  logic [7:0]    hex1_reg, hex1_next;
  logic [7:0]    hex5_reg, hex5_next;
  logic          unused_switches;

  // Active-low hex digit, decimal point off
  function automatic logic [7:0] seg7(input logic [3:0] d);
    case (d)
      4'h0: seg7 = 8'hC0;  4'h1: seg7 = 8'hF9;  4'h2: seg7 = 8'hA4;  4'h3: seg7 = 8'hB0;
      4'h4: seg7 = 8'h99;  4'h5: seg7 = 8'h92;  4'h6: seg7 = 8'h82;  4'h7: seg7 = 8'hF8;
      4'h8: seg7 = 8'h80;  4'h9: seg7 = 8'h90;  4'hA: seg7 = 8'h88;  4'hB: seg7 = 8'h83;
      4'hC: seg7 = 8'hC6;  4'hD: seg7 = 8'hA1;  4'hE: seg7 = 8'h86;  default: seg7 = 8'h8E;
    endcase
  endfunction

  assign press           = s2_reg & ~s3_reg;
  assign g               = bus.switches[3:0];
  assign tries_inc       = attempts_reg + 4'd1;
  assign unused_switches = ^bus.switches[9:4];

  // Next-state and next-output computation; displays follow the next state
  always_comb begin
    state_next    = state_reg;
    secret_next   = secret_reg;
    guess_next    = guess_reg;
    attempts_next = attempts_reg;
    timer_next    = timer_reg;
    res_next      = res_reg;
    case (state_reg)
      SETUP: begin
        if (press) begin
          secret_next   = g;
          attempts_next = 4'd0;
          res_next      = 3'b000;
          state_next    = GUESS;
        end
      end
      GUESS: begin
        if (press) begin
          guess_next    = g;
          attempts_next = tries_inc;
          if (g < secret_reg)      res_next = 3'b001;
          else if (g > secret_reg) res_next = 3'b010;
          else                     res_next = 3'b100;
          // A correct guess wins even on the last allowed try
          if (g == secret_reg) begin
            state_next = WIN;
          end else if (tries_inc == 4'(MAX_TRIES)) begin
            state_next = LOSE;
          end else begin
            state_next = HOLD;
            timer_next = TW'(HOLD_CYCLES - 1);
          end
        end
      end
      HOLD: begin
        // Presses are dropped while the result is held
        if (timer_reg == '0) state_next = GUESS;
        else                 timer_next = timer_reg - 1'b1;
      end
      WIN, LOSE: begin
        if (press) begin
          attempts_next = 4'd0;
          res_next      = 3'b000;
          state_next    = SETUP;
        end
      end
      default: state_next = SETUP;
    endcase

    leds_next = {state_next == WIN, state_next == LOSE, attempts_next,
                 state_next == SETUP, res_next};

    case (state_next)
      SETUP:   hex0_next = GLYPH_BLANK;
      GUESS:   hex0_next = seg7(g);
      LOSE:    hex0_next = seg7(secret_next);
      default: hex0_next = seg7(guess_next);
    endcase

    hex1_next = (state_next == SETUP) ? GLYPH_BLANK : seg7(attempts_next);

    case (res_next)
      3'b001:  hex5_next = GLYPH_L;
      3'b010:  hex5_next = GLYPH_H;
      3'b100:  hex5_next = GLYPH_E;
      default: hex5_next = GLYPH_BLANK;
    endcase
  end

  // State, datapath, button history and display registers
  always_ff @(posedge clk) begin
    if (reset) begin
      // Synchroniser preset high so a button held through reset is not a press
      s1_reg       <= 1'b1;
      s2_reg       <= 1'b1;
      s3_reg       <= 1'b1;
      state_reg    <= SETUP;
      secret_reg   <= 4'd0;
      guess_reg    <= 4'd0;
      attempts_reg <= 4'd0;
      timer_reg    <= '0;
      res_reg      <= 3'b000;
      leds_reg     <= 10'd0;
      hex0_reg     <= GLYPH_BLANK;
      hex1_reg     <= GLYPH_BLANK;
      hex5_reg     <= GLYPH_BLANK;
    end else begin
      s1_reg       <= bus.btn;
      s2_reg       <= s1_reg;
      s3_reg       <= s2_reg;
      state_reg    <= state_next;
      secret_reg   <= secret_next;
      guess_reg    <= guess_next;
      attempts_reg <= attempts_next;
      timer_reg    <= timer_next;
      res_reg      <= res_next;
      leds_reg     <= leds_next;
      hex0_reg     <= hex0_next;
      hex1_reg     <= hex1_next;
      hex5_reg     <= hex5_next;
    end
  end

  assign bus.leds = leds_reg;
  assign bus.hex0 = hex0_reg;
  assign bus.hex1 = hex1_reg;
  assign bus.hex2 = GLYPH_BLANK;
  assign bus.hex3 = GLYPH_BLANK;
  assign bus.hex4 = GLYPH_BLANK;
  assign bus.hex5 = hex5_reg;

endmodule

// File: tb/tb_guess_game_ctrl.sv
// Scoreboard bench for guess_game_ctrl (MAX_TRIES=3, HOLD_CYCLES=4).
// Stimulus pushes expected display snapshots tagged with the cycle they
// must appear on; a negedge monitor pops and compares them.
module tb_guess_game_ctrl;

  localparam int MAXT   = 3;
  localparam int HOLD_T = 4;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  guess_game_ctrl_if bus();

  guess_game_ctrl #(.MAX_TRIES(MAXT), .HOLD_CYCLES(HOLD_T)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  typedef struct {
    string      nm;
    int         due;
    logic [9:0] leds;
    logic [7:0] h0;
    bit         c0;
    logic [7:0] h1;
    bit         c1;
    logic [7:0] h5;
  } exp_t;

  exp_t exp_q[$];

  function automatic void push(input string nm, input int due, input logic [9:0] l,
                               input logic [7:0] h0, input bit c0,
                               input logic [7:0] h1, input bit c1,
                               input logic [7:0] h5);
    exp_t e;
    e.nm = nm; e.due = due; e.leds = l;
    e.h0 = h0; e.c0 = c0; e.h1 = h1; e.c1 = c1; e.h5 = h5;
    exp_q.push_back(e);
  endfunction

  function automatic void chk(input string nm, input string fld,
                              input logic [9:0] act, input logic [9:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s.%s actual=%h required=%h", nm, fld, act, req);
    end
  endfunction

  // Monitor: compare every expectation whose cycle has arrived
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      exp_t e;
      e = exp_q.pop_front();
      $display("TXN %-18s cycle=%0d leds=%h hex0=%h hex1=%h hex5=%h",
               e.nm, cyc, bus.leds, bus.hex0, bus.hex1, bus.hex5);
      chk(e.nm, "leds", bus.leds, e.leds);
      if (e.c0) chk(e.nm, "hex0", {2'b00, bus.hex0}, {2'b00, e.h0});
      if (e.c1) chk(e.nm, "hex1", {2'b00, bus.hex1}, {2'b00, e.h1});
      chk(e.nm, "hex5", {2'b00, bus.hex5}, {2'b00, e.h5});
      chk(e.nm, "hex234", {2'b00, bus.hex2 & bus.hex3 & bus.hex4}, 10'h0FF);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One clean press with guess/secret g; result visible 3 edges after btn rises
  task automatic press_exp(input string nm, input logic [3:0] g, input logic [9:0] l,
                           input logic [7:0] h0, input bit c0,
                           input logic [7:0] h1, input bit c1,
                           input logic [7:0] h5);
    bus.switches = {6'd0, g};
    push(nm, cyc + 3, l, h0, c0, h1, c1, h5);
    bus.btn = 1'b1;
    tick(3);
    bus.btn = 1'b0;
    tick(3 + HOLD_T);
  endtask

  initial begin
    int c;
    #200000;
    $display("FAIL watchdog cycle=%0d required=finish", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int c;
    reset = 1'b1;
    bus.btn = 1'b1;
    bus.switches = 10'd0;
    tick(2);
    // Reset values, then button held across reset release gives no press
    push("reset_values", cyc, 10'h000, 8'hFF, 1, 8'hFF, 1, 8'hFF);
    reset = 1'b0;
    push("setup_idle", cyc + 1, 10'h008, 8'hFF, 1, 8'hFF, 0, 8'hFF);
    push("held_thru_reset", cyc + 8, 10'h008, 8'hFF, 1, 8'hFF, 0, 8'hFF);
    tick(10);
    bus.btn = 1'b0;
    tick(3);

    // Round A: secret 9, exact press latency
    bus.switches = 10'h009;
    c = cyc;
    push("latency_before", c + 2, 10'h008, 8'hFF, 1, 8'hFF, 0, 8'hFF);
    push("secret9_guess", c + 3, 10'h000, 8'h90, 1, 8'hC0, 1, 8'hFF);
    bus.btn = 1'b1;
    tick(3);
    bus.btn = 1'b0;
    tick(3);
    press_exp("a_guess3_low", 4'h3, 10'h011, 8'hB0, 1, 8'hF9, 1, 8'hC7);

    // Guess C, then a second press lands inside HOLD and must be ignored
    bus.switches = 10'h00C;
    c = cyc;
    push("a_guessC_high", c + 3, 10'h022, 8'hC6, 1, 8'hA4, 1, 8'h89);
    push("a_hold_ignore", c + 6, 10'h022, 8'hC6, 1, 8'hA4, 1, 8'h89);
    push("a_hold_exit", c + 7, 10'h022, 8'h92, 1, 8'hA4, 1, 8'h89);
    bus.btn = 1'b1; tick(1);
    bus.btn = 1'b0; tick(1);
    bus.btn = 1'b1; tick(1);
    bus.switches = 10'h005;
    tick(4);
    bus.btn = 1'b0;
    tick(3);
    press_exp("a_win_last_try", 4'h9, 10'h234, 8'h90, 1, 8'hB0, 1, 8'h86);
    press_exp("a_win_to_setup", 4'h0, 10'h008, 8'hFF, 1, 8'hFF, 0, 8'hFF);

    // Round B: secret 9, guesses 3 then 9
    press_exp("b_secret9", 4'h9, 10'h000, 8'h90, 1, 8'hC0, 1, 8'hFF);
    press_exp("b_guess3", 4'h3, 10'h011, 8'hB0, 1, 8'hF9, 1, 8'hC7);
    press_exp("b_win_2", 4'h9, 10'h224, 8'h90, 1, 8'hA4, 1, 8'h86);
    press_exp("b_to_setup", 4'h1, 10'h008, 8'hFF, 1, 8'hFF, 0, 8'hFF);

    // Round C: secret 0, guesses 1,2,3 -> LOSE showing the secret
    press_exp("c_secret0", 4'h0, 10'h000, 8'hC0, 1, 8'hC0, 1, 8'hFF);
    press_exp("c_guess1", 4'h1, 10'h012, 8'hF9, 1, 8'hF9, 1, 8'h89);
    press_exp("c_guess2", 4'h2, 10'h022, 8'hA4, 1, 8'hA4, 1, 8'h89);
    press_exp("c_lose", 4'h3, 10'h132, 8'hC0, 1, 8'hB0, 1, 8'h89);
    press_exp("c_to_setup", 4'h3, 10'h008, 8'hFF, 1, 8'hFF, 0, 8'hFF);

    // Round D: secret F, held button counts once, reset during HOLD
    press_exp("d_secretF", 4'hF, 10'h000, 8'h8E, 1, 8'hC0, 1, 8'hFF);
    bus.switches = 10'h000;
    c = cyc;
    push("d_held_first", c + 3, 10'h011, 8'hC0, 1, 8'hF9, 1, 8'hC7);
    push("d_held_100", c + 100, 10'h011, 8'hC0, 1, 8'hF9, 1, 8'hC7);
    bus.btn = 1'b1;
    tick(100);
    bus.btn = 1'b0;
    tick(3);
    c = cyc;
    push("d_guess_hold", c + 3, 10'h021, 8'hC0, 1, 8'hA4, 1, 8'hC7);
    bus.btn = 1'b1;
    tick(3);
    reset = 1'b1;
    push("d_reset_in_hold", c + 4, 10'h000, 8'hFF, 1, 8'hFF, 1, 8'hFF);
    tick(1);
    reset = 1'b0;
    bus.btn = 1'b0;
    push("d_after_reset", c + 5, 10'h008, 8'hFF, 1, 8'hFF, 0, 8'hFF);
    tick(3);
    press_exp("d_attempts_zero", 4'h5, 10'h000, 8'h92, 1, 8'hC0, 1, 8'hFF);

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 50 && exp_q.size() > 0; i++) tick(1);
    tick(2);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
